// File: rtl/bus_arbiter_n.sv
// bus_arbiter_n: N-master arbiter for the ADS serial bus.
// Fixed-priority or round-robin selection chosen at elaboration. One
// outstanding split transaction is tracked against the split-capable
// slave, and an optional hold timeout pre-empts long grants.
module bus_arbiter_n #(
  parameter int NUM_MASTERS = 4,
  parameter int RR_MODE     = 0,
  parameter int MAX_HOLD    = 0,
  localparam int MW = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] breq,
  input  logic                   sready_nsplit,
  input  logic                   sreadysp,
  input  logic                   ssplit,
  output logic [NUM_MASTERS-1:0] bgrant,
  output logic [MW-1:0]          msel,
  output logic [NUM_MASTERS-1:0] msplit,
  output logic                   split_grant
);

  localparam int HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int HOLD_LAST = (MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0;
  localparam logic [HW-1:0] HOLD_LAST_V = HW'(HOLD_LAST);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t                 state_r;
  logic [MW-1:0]          owner_r;
  logic                   sp_valid_r;
  logic [MW-1:0]          sp_owner_r;
  logic [MW-1:0]          rr_ptr_r;
  logic [HW-1:0]          hold_cnt_r;
  logic                   split_grant_r;

  logic [NUM_MASTERS-1:0] req_mask_s;
  logic [MW-1:0]          cand_s;
  logic                   cand_any_s;
  logic                   timeout_s;

  // One-hot decode of a master index.
  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [MW-1:0] idx);
    onehot = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Successor index, wrapping at NUM_MASTERS.
  function automatic logic [MW-1:0] next_idx(input logic [MW-1:0] idx);
    next_idx = (int'(idx) == NUM_MASTERS - 1) ? {MW{1'b0}} : (idx + MW'(1));
  endfunction

  // Lowest set index of the mask (scan downward so the last hit wins).
  function automatic logic [MW-1:0] pick_fixed(input logic [NUM_MASTERS-1:0] m);
    pick_fixed = {MW{1'b0}};
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      pick_fixed = m[i] ? MW'(i) : pick_fixed;
    end
  endfunction

  // First set index at or after ptr, wrapping; scanned backwards from the
  // farthest offset so the nearest hit is the final assignment.
  function automatic logic [MW-1:0] pick_rr(input logic [NUM_MASTERS-1:0] m,
                                            input logic [MW-1:0] ptr);
    int idx;
    pick_rr = {MW{1'b0}};
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      idx     = (int'(ptr) + k) % NUM_MASTERS;
      pick_rr = m[idx] ? MW'(idx) : pick_rr;
    end
  endfunction

  // Eligible requesters and the arbitration winner among them.
  always_comb begin
    req_mask_s = breq;
    if (ssplit) begin
      req_mask_s = breq & ~onehot(sp_owner_r);
    end else begin
      req_mask_s = breq;
    end
    if (RR_MODE != 0) begin
      cand_s = pick_rr(req_mask_s, rr_ptr_r);
    end else begin
      cand_s = pick_fixed(req_mask_s);
    end
    cand_any_s = |req_mask_s;
  end

  // Hold timeout fires on the last allowed cycle while someone else waits.
  always_comb begin
    timeout_s = (MAX_HOLD > 0) && (hold_cnt_r == HOLD_LAST_V) && (|(breq & ~bgrant));
  end

  // Arbitration state machine, split tracking and hold counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r       <= ST_IDLE;
      owner_r       <= {MW{1'b0}};
      sp_valid_r    <= 1'b0;
      sp_owner_r    <= {MW{1'b0}};
      rr_ptr_r      <= {MW{1'b0}};
      hold_cnt_r    <= {HW{1'b0}};
      split_grant_r <= 1'b0;
    end else begin
      split_grant_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!ssplit && sp_valid_r) begin
            // Split resume outranks every fresh request.
            state_r    <= ST_GRANT;
            owner_r    <= sp_owner_r;
            rr_ptr_r   <= next_idx(sp_owner_r);
            hold_cnt_r <= {HW{1'b0}};
          end else if (!ssplit && sready_nsplit && sreadysp && cand_any_s) begin
            state_r    <= ST_GRANT;
            owner_r    <= cand_s;
            rr_ptr_r   <= next_idx(cand_s);
            hold_cnt_r <= {HW{1'b0}};
          end else if (ssplit && sp_valid_r && sready_nsplit && cand_any_s) begin
            // Split slave busy: others may still use non-split slaves.
            state_r    <= ST_GRANT;
            owner_r    <= cand_s;
            rr_ptr_r   <= next_idx(cand_s);
            hold_cnt_r <= {HW{1'b0}};
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (hold_cnt_r == HOLD_LAST_V) begin
            hold_cnt_r <= hold_cnt_r;
          end else begin
            hold_cnt_r <= hold_cnt_r + HW'(1);
          end
          if (sp_valid_r && (owner_r == sp_owner_r) && !ssplit) begin
            sp_valid_r    <= 1'b0;
            split_grant_r <= 1'b1;
            rr_ptr_r      <= next_idx(owner_r);
          end else begin
            sp_valid_r <= sp_valid_r;
          end
          if (!breq[owner_r]) begin
            state_r <= ST_IDLE;
          end else if (!sp_valid_r && ssplit) begin
            state_r    <= ST_IDLE;
            sp_valid_r <= 1'b1;
            sp_owner_r <= owner_r;
          end else if (timeout_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_GRANT;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bgrant      = (state_r == ST_GRANT) ? onehot(owner_r) : {NUM_MASTERS{1'b0}};
  assign msel        = (state_r == ST_GRANT) ? owner_r : {MW{1'b0}};
  assign msplit      = sp_valid_r ? onehot(sp_owner_r) : {NUM_MASTERS{1'b0}};
  assign split_grant = split_grant_r;

endmodule

// File: tb/tb_bus_arbiter_n.sv
// tb_bus_arbiter_n: scoreboard bench for bus_arbiter_n. Three instances
// share the stimulus: fixed priority, round-robin, and round-robin with a
// 5-cycle hold timeout. Each cycle names the instance it checks.
module tb_bus_arbiter_n;

  logic       clk;
  logic       rstn;
  logic [3:0] breq;
  logic       sready_nsplit;
  logic       sreadysp;
  logic       ssplit;

  logic [3:0] fx_bgrant, rr_bgrant, to_bgrant;
  logic [1:0] fx_msel,   rr_msel,   to_msel;
  logic [3:0] fx_msplit, rr_msplit, to_msplit;
  logic       fx_sg,     rr_sg,     to_sg;

  bus_arbiter_n #(.NUM_MASTERS(4), .RR_MODE(0), .MAX_HOLD(0)) u_fix (
    .clk(clk), .rstn(rstn), .breq(breq), .sready_nsplit(sready_nsplit),
    .sreadysp(sreadysp), .ssplit(ssplit), .bgrant(fx_bgrant), .msel(fx_msel),
    .msplit(fx_msplit), .split_grant(fx_sg)
  );

  bus_arbiter_n #(.NUM_MASTERS(4), .RR_MODE(1), .MAX_HOLD(0)) u_rr (
    .clk(clk), .rstn(rstn), .breq(breq), .sready_nsplit(sready_nsplit),
    .sreadysp(sreadysp), .ssplit(ssplit), .bgrant(rr_bgrant), .msel(rr_msel),
    .msplit(rr_msplit), .split_grant(rr_sg)
  );

  bus_arbiter_n #(.NUM_MASTERS(4), .RR_MODE(1), .MAX_HOLD(5)) u_to (
    .clk(clk), .rstn(rstn), .breq(breq), .sready_nsplit(sready_nsplit),
    .sreadysp(sreadysp), .ssplit(ssplit), .bgrant(to_bgrant), .msel(to_msel),
    .msplit(to_msplit), .split_grant(to_sg)
  );

  typedef struct {
    int         step;
    int         sel;
    logic [3:0] bg;
    logic [1:0] ms;
    logic [3:0] sp;
    logic       sg;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total_cnt = 0;
  int   bad_cnt   = 0;
  int   step_cnt  = 0;
  int   cur_step  = 0;

  logic [3:0] obs_bg;
  logic [1:0] obs_ms;
  logic [3:0] obs_sp;
  logic       obs_sg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s step=%0d got=%0h want=%0h", tag, cur_step, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue what the chosen DUT must show after the next edge.
  task automatic drv(input logic [3:0] b, input logic ns, input logic sp, input logic ss,
                     input logic rn, input int sel, input logic [3:0] eb,
                     input logic [1:0] em, input logic [3:0] es, input logic eg);
    exp_t e;
    @(negedge clk);
    breq          = b;
    sready_nsplit = ns;
    sreadysp      = sp;
    ssplit        = ss;
    rstn          = rn;
    step_cnt++;
    e.step = step_cnt; e.sel = sel; e.bg = eb; e.ms = em; e.sp = es; e.sg = eg;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    drv(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 0, 4'b0000, 2'd0, 4'b0000, 1'b0);
  endtask

  // Monitor: pop one expectation per edge and compare against the selected DUT.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e    = sb_q.pop_front();
      cur_step = mon_e.step;
      case (mon_e.sel)
        0:       begin obs_bg = fx_bgrant; obs_ms = fx_msel; obs_sp = fx_msplit; obs_sg = fx_sg; end
        1:       begin obs_bg = rr_bgrant; obs_ms = rr_msel; obs_sp = rr_msplit; obs_sg = rr_sg; end
        default: begin obs_bg = to_bgrant; obs_ms = to_msel; obs_sp = to_msplit; obs_sg = to_sg; end
      endcase
      chk("bgrant",      32'(obs_bg), 32'(mon_e.bg));
      chk("msel",        32'(obs_ms), 32'(mon_e.ms));
      chk("msplit",      32'(obs_sp), 32'(mon_e.sp));
      chk("split_grant", 32'(obs_sg), 32'(mon_e.sg));
    end
  end

  initial begin
    rstn = 1'b0; breq = 4'b0000; sready_nsplit = 1'b1; sreadysp = 1'b1; ssplit = 1'b0;

    // Fixed priority: 1010 -> master 1, drop it -> idle cycle -> master 3.
    do_reset();
    drv(4'b1010, 1'b1, 1'b1, 1'b0, 1'b1, 0, 4'b0010, 2'd1, 4'b0000, 1'b0);
    drv(4'b1010, 1'b1, 1'b1, 1'b0, 1'b1, 0, 4'b0010, 2'd1, 4'b0000, 1'b0);
    drv(4'b1000, 1'b1, 1'b1, 1'b0, 1'b1, 0, 4'b0000, 2'd0, 4'b0000, 1'b0);
    drv(4'b1000, 1'b1, 1'b1, 1'b0, 1'b1, 0, 4'b1000, 2'd3, 4'b0000, 1'b0);
    drv(4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 0, 4'b0000, 2'd0, 4'b0000, 1'b0);

    // Round-robin: order 0,1,2,3,0 with two-cycle grants.
    do_reset();
    for (int m = 0; m < 4; m++) begin
      drv(4'b1111, 1'b1, 1'b1, 1'b0, 1'b1, 1, 4'(1 << m), 2'(m), 4'b0000, 1'b0);
      drv(4'b1111, 1'b1, 1'b1, 1'b0, 1'b1, 1, 4'(1 << m), 2'(m), 4'b0000, 1'b0);
      drv(4'b1111 & ~4'(1 << m), 1'b1, 1'b1, 1'b0, 1'b1, 1, 4'b0000, 2'd0, 4'b0000, 1'b0);
    end
    drv(4'b1111, 1'b1, 1'b1, 1'b0, 1'b1, 1, 4'b0001, 2'd0, 4'b0000, 1'b0);
    drv(4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 1, 4'b0000, 2'd0, 4'b0000, 1'b0);

    // Split: master 0 splits, master 2 uses the bus, master 0 resumes over master 1.
    do_reset();
    drv(4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, 0, 4'b0001, 2'd0, 4'b0000, 1'b0);
    drv(4'b0001, 1'b1, 1'b1, 1'b1, 1'b1, 0, 4'b0000, 2'd0, 4'b0001, 1'b0);
    drv(4'b0101, 1'b1, 1'b1, 1'b1, 1'b1, 0, 4'b0100, 2'd2, 4'b0001, 1'b0);
    drv(4'b0101, 1'b1, 1'b1, 1'b1, 1'b1, 0, 4'b0100, 2'd2, 4'b0001, 1'b0);
    drv(4'b0001, 1'b1, 1'b1, 1'b1, 1'b1, 0, 4'b0000, 2'd0, 4'b0001, 1'b0);
    drv(4'b0011, 1'b1, 1'b1, 1'b0, 1'b1, 0, 4'b0001, 2'd0, 4'b0001, 1'b0);
    drv(4'b0011, 1'b1, 1'b1, 1'b0, 1'b1, 0, 4'b0001, 2'd0, 4'b0000, 1'b1);
    drv(4'b0011, 1'b1, 1'b1, 1'b0, 1'b1, 0, 4'b0001, 2'd0, 4'b0000, 1'b0);
    drv(4'b0010, 1'b1, 1'b1, 1'b0, 1'b1, 0, 4'b0000, 2'd0, 4'b0000, 1'b0);
    drv(4'b0010, 1'b1, 1'b1, 1'b0, 1'b1, 0, 4'b0010, 2'd1, 4'b0000, 1'b0);
    drv(4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 0, 4'b0000, 2'd0, 4'b0000, 1'b0);

    // Timeout (MAX_HOLD=5): master 0 held 5 cycles, one idle, then master 3.
    do_reset();
    drv(4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, 2, 4'b0001, 2'd0, 4'b0000, 1'b0);
    for (int c = 0; c < 4; c++) begin
      drv(4'b1001, 1'b1, 1'b1, 1'b0, 1'b1, 2, 4'b0001, 2'd0, 4'b0000, 1'b0);
    end
    drv(4'b1001, 1'b1, 1'b1, 1'b0, 1'b1, 2, 4'b0000, 2'd0, 4'b0000, 1'b0);
    drv(4'b1001, 1'b1, 1'b1, 1'b0, 1'b1, 2, 4'b1000, 2'd3, 4'b0000, 1'b0);
    drv(4'b1001, 1'b1, 1'b1, 1'b0, 1'b1, 2, 4'b1000, 2'd3, 4'b0000, 1'b0);
    drv(4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, 2, 4'b0000, 2'd0, 4'b0000, 1'b0);
    drv(4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, 2, 4'b0001, 2'd0, 4'b0000, 1'b0);
    drv(4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 2, 4'b0000, 2'd0, 4'b0000, 1'b0);

    // Reset mid-split: split owned by master 2, master 0 granted, then reset.
    do_reset();
    drv(4'b0100, 1'b1, 1'b1, 1'b0, 1'b1, 0, 4'b0100, 2'd2, 4'b0000, 1'b0);
    drv(4'b0100, 1'b1, 1'b1, 1'b1, 1'b1, 0, 4'b0000, 2'd0, 4'b0100, 1'b0);
    drv(4'b0101, 1'b1, 1'b1, 1'b1, 1'b1, 0, 4'b0001, 2'd0, 4'b0100, 1'b0);
    drv(4'b0101, 1'b1, 1'b1, 1'b1, 1'b0, 0, 4'b0000, 2'd0, 4'b0000, 1'b0);
    drv(4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, 0, 4'b0001, 2'd0, 4'b0000, 1'b0);
    drv(4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, 0, 4'b0001, 2'd0, 4'b0000, 1'b0);
    drv(4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 0, 4'b0000, 2'd0, 4'b0000, 1'b0);

    // Ready gating: no grant until the split-capable slave is ready.
    do_reset();
    drv(4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 0, 4'b0000, 2'd0, 4'b0000, 1'b0);
    drv(4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 0, 4'b0000, 2'd0, 4'b0000, 1'b0);
    drv(4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, 0, 4'b0001, 2'd0, 4'b0000, 1'b0);
    drv(4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 0, 4'b0000, 2'd0, 4'b0000, 1'b0);

    repeat (2) @(posedge clk);
    #2;
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
